// File: rtl/sb_spi_target_pkg.sv
// Shared definitions for the SB-bus SPI target: register map, bit positions,
// bus handshake states and the STATUS byte packer.
package sb_spi_target_pkg;

  localparam logic [3:0] OFF_CTRL   = 4'd0;
  localparam logic [3:0] OFF_STATUS = 4'd1;
  localparam logic [3:0] OFF_TXDR   = 4'd2;
  localparam logic [3:0] OFF_RXDR   = 4'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_CPOL = 1;
  localparam int CTRL_CPHA = 2;
  localparam int CTRL_RXIE = 3;

  localparam int ST_OVR = 2;

  localparam logic [7:0] IDLE_TX_DEF = 8'hFF;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_ACK,
    BUS_HOLD
  } bus_state_t;

  function automatic logic [7:0] status_byte(input logic busy, input logic ovr,
                                             input logic txempty, input logic rxrdy);
    return {4'b0000, busy, ovr, txempty, rxrdy};
  endfunction

endpackage

// File: rtl/sb_spi_target_shifter.sv
// SPI-side datapath: input synchronisers, sclk edge detect, bit counter and the
// TX/RX shift registers. Byte completions and TX loads are single-cycle pulses.
module sb_spi_target_shifter
  import sb_spi_target_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sclk,
  input  logic       spi_csn,
  input  logic       spi_mosi,
  input  logic       en,
  input  logic       cpol,
  input  logic       cpha,
  input  logic [7:0] tx_byte,
  output logic       tx_load,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       csn_low,
  output logic       miso,
  output logic       miso_oe
);

  logic [SYNC_STAGES-1:0] sclk_sync, csn_sync, mosi_sync;
  logic                   sclk_s, csn_s, mosi_s;
  logic                   sclk_d, csn_d;
  logic                   mode_cpol, mode_cpha, frame;
  logic [2:0]             cnt;
  logic [7:0]             tx_sh;
  logic [6:0]             rx_sh;
  logic                   act, start, rise, fall, lead, trail, sample_ev, shift_ev;

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign csn_s   = csn_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign csn_low = ~csn_s;

  assign act   = ~csn_s & en;
  assign start = csn_d & ~csn_s & en;
  assign rise  = sclk_s & ~sclk_d;
  assign fall  = ~sclk_s & sclk_d;
  assign lead  = mode_cpol ? fall : rise;
  assign trail = mode_cpol ? rise : fall;

  // The first shift of every byte is suppressed (cnt==0): in CPHA=0 it is the
  // trailing edge right after a reload, in CPHA=1 the leading edge that merely
  // presents the already-loaded MSB.
  assign sample_ev = frame & act & (mode_cpha ? trail : lead);
  assign shift_ev  = frame & act & (mode_cpha ? lead : trail) & (cnt != 3'd0);

  assign rx_valid = sample_ev & (cnt == 3'd7);
  assign rx_byte  = {rx_sh, mosi_s};
  assign tx_load  = start | rx_valid;
  assign miso     = tx_sh[7];

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '1;
      csn_sync  <= '1;
      mosi_sync <= '1;
      sclk_d    <= 1'b1;
      csn_d     <= 1'b1;
      mode_cpol <= 1'b0;
      mode_cpha <= 1'b0;
      frame     <= 1'b0;
      cnt       <= 3'd0;
      tx_sh     <= 8'hFF;
      rx_sh     <= 7'd0;
      miso_oe   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_d    <= sclk_s;
      csn_d     <= csn_s;

      if (!act) begin
        frame <= 1'b0;
        cnt   <= 3'd0;
      end else if (start) begin
        frame     <= 1'b1;
        cnt       <= 3'd0;
        mode_cpol <= cpol;
        mode_cpha <= cpha;
      end else if (sample_ev) begin
        cnt   <= cnt + 3'd1;
        rx_sh <= rx_byte[6:0];
      end

      if (tx_load)
        tx_sh <= tx_byte;
      else if (shift_ev)
        tx_sh <= {tx_sh[6:0], 1'b1};

      miso_oe <= act & (frame | start);
    end
  end

endmodule

// File: rtl/sb_spi_target.sv
// SB-bus SPI target: bus handshake FSM and CTRL/STATUS/TXDR/RXDR registers around
// the SPI shifter. Read data and ack are zero when idle so the bus can OR them.
module sb_spi_target
  import sb_spi_target_pkg::*;
#(
  parameter logic [3:0] BUS_ADDR74  = 4'b0011,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_TX     = IDLE_TX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sb_stbi,
  input  logic       sb_rwi,
  input  logic [7:0] sb_adri,
  input  logic [7:0] sb_dati,
  output logic [7:0] sb_dato,
  output logic       sb_acko,
  input  logic       spi_sclk,
  input  logic       spi_csn,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       irq
);

  bus_state_t bus_st;
  logic [3:0] ctrl;
  logic [7:0] txdr, rxdr, rd_val, tx_byte, rx_byte;
  logic       rxrdy, txempty, ovr;
  logic       hit, wr, rd, busy, csn_low, tx_load, rx_valid;
  logic [3:0] off;
  logic       rd_rxdr;

  // A strobe is served once; further acks wait until the master drops it.
  assign hit     = sb_stbi & (sb_adri[7:4] == BUS_ADDR74) & (bus_st == BUS_IDLE);
  assign wr      = hit & sb_rwi;
  assign rd      = hit & ~sb_rwi;
  assign off     = sb_adri[3:0];
  assign rd_rxdr = rd & (off == OFF_RXDR);

  assign busy    = csn_low & ctrl[CTRL_EN];
  assign tx_byte = txempty ? IDLE_TX : txdr;
  assign irq     = (rxrdy & ctrl[CTRL_RXIE]) | ovr;

  always_comb begin
    rd_val = 8'h00;
    case (off)
      OFF_CTRL:   rd_val = {4'b0000, ctrl};
      OFF_STATUS: rd_val = status_byte(busy, ovr, txempty, rxrdy);
      OFF_RXDR:   rd_val = rxdr;
      default:    rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_st  <= BUS_IDLE;
      sb_acko <= 1'b0;
      sb_dato <= 8'h00;
    end else begin
      sb_acko <= hit;
      sb_dato <= rd ? rd_val : 8'h00;
      case (bus_st)
        BUS_IDLE: if (hit) bus_st <= BUS_ACK;
        BUS_ACK:  bus_st <= sb_stbi ? BUS_HOLD : BUS_IDLE;
        BUS_HOLD: if (!sb_stbi) bus_st <= BUS_IDLE;
        default:  bus_st <= BUS_IDLE;
      endcase
    end
  end

  // Statement order encodes the same-cycle priorities: a TXDR write beats the
  // shifter consuming it, an RXDR read frees the slot for a completing byte, and
  // an overrun beats a software OVR clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl    <= 4'd0;
      txdr    <= 8'h00;
      rxdr    <= 8'h00;
      rxrdy   <= 1'b0;
      txempty <= 1'b1;
      ovr     <= 1'b0;
    end else begin
      if (tx_load)
        txempty <= 1'b1;
      if (wr && off == OFF_CTRL)
        ctrl <= sb_dati[3:0];
      if (wr && off == OFF_TXDR) begin
        txdr    <= sb_dati;
        txempty <= 1'b0;
      end
      if (wr && off == OFF_STATUS && sb_dati[ST_OVR])
        ovr <= 1'b0;
      if (rd_rxdr)
        rxrdy <= 1'b0;
      if (rx_valid) begin
        if (rxrdy && !rd_rxdr) begin
          ovr <= 1'b1;
        end else begin
          rxdr  <= rx_byte;
          rxrdy <= 1'b1;
        end
      end
    end
  end

  sb_spi_target_shifter #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .spi_sclk (spi_sclk),
    .spi_csn  (spi_csn),
    .spi_mosi (spi_mosi),
    .en       (ctrl[CTRL_EN]),
    .cpol     (ctrl[CTRL_CPOL]),
    .cpha     (ctrl[CTRL_CPHA]),
    .tx_byte  (tx_byte),
    .tx_load  (tx_load),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .csn_low  (csn_low),
    .miso     (spi_miso),
    .miso_oe  (spi_miso_oe)
  );

endmodule
